// File: rtl/dram_cmd_responder.sv
// DRAM device-side responder for the cmd_req/cmd_ack four-phase handshake.
// Tracks the open row per bank, applies per-command latency, then strobes the array.
module dram_cmd_responder #(
  parameter int NUMBER_OF_BANKS = 8,
  parameter int NUMBER_OF_ROWS  = 128,
  parameter int NUMBER_OF_COLS  = 8,
  parameter int T_RCD           = 3,
  parameter int T_RP            = 3,
  parameter int T_CL            = 4,
  parameter int T_WR            = 5,
  parameter int T_RFC           = 8
) (
  input  logic                                                     clk,
  input  logic                                                     rst_b,
  input  logic                                                     cmd_req,
  input  logic [1:0]                                               cmd,
  input  logic [((NUMBER_OF_BANKS > 1) ? $clog2(NUMBER_OF_BANKS) : 1)-1:0] bank_id,
  input  logic [((NUMBER_OF_ROWS > 1) ? $clog2(NUMBER_OF_ROWS) : 1)-1:0]   row_id,
  input  logic [((NUMBER_OF_COLS > 1) ? $clog2(NUMBER_OF_COLS) : 1)-1:0]   col_id,
  output logic                                                     cmd_ack,
  output logic                                                     busy,
  output logic                                                     cmd_err,
  output logic                                                     exec_rd,
  output logic                                                     exec_wr,
  output logic [((NUMBER_OF_BANKS > 1) ? $clog2(NUMBER_OF_BANKS) : 1)-1:0] exec_bank,
  output logic [((NUMBER_OF_ROWS > 1) ? $clog2(NUMBER_OF_ROWS) : 1)-1:0]   exec_row,
  output logic [((NUMBER_OF_COLS > 1) ? $clog2(NUMBER_OF_COLS) : 1)-1:0]   exec_col,
  output logic [NUMBER_OF_BANKS-1:0]                               open_mask
);

  localparam int BW    = (NUMBER_OF_BANKS > 1) ? $clog2(NUMBER_OF_BANKS) : 1;
  localparam int RW    = (NUMBER_OF_ROWS > 1) ? $clog2(NUMBER_OF_ROWS) : 1;
  localparam int T_M1  = (T_RCD > T_CL) ? T_RCD : T_CL;
  localparam int T_M2  = (T_WR > T_RFC) ? T_WR : T_RFC;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CNT_W = $clog2(T_RP + T_MAX) + 1;

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_REF = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    ACK  = 2'b10
  } state_t;

  state_t           state;
  logic [1:0]       exec_cmd;
  logic             exec_illegal;
  logic [CNT_W-1:0] cnt;
  logic [RW-1:0]    open_row [NUMBER_OF_BANKS];

  logic             bank_open;
  logic             row_hit;
  logic             req_illegal;
  logic [CNT_W-1:0] load_val;
  logic             done;

  // Latency is decided from the live bank state at the accepting edge; the counter holds L-1.
  always_comb begin
    bank_open   = open_mask[bank_id];
    row_hit     = (open_row[bank_id] == row_id);
    req_illegal = 1'b0;
    load_val    = '0;
    case (cmd)
      CMD_ACT: begin
        if (!bank_open)   load_val = CNT_W'(T_RCD - 1);
        else if (row_hit) load_val = '0;
        else              load_val = CNT_W'(T_RP + T_RCD - 1);
      end
      CMD_RD: begin
        if (!bank_open || !row_hit) req_illegal = 1'b1;
        else                        load_val    = CNT_W'(T_CL - 1);
      end
      CMD_WR: begin
        if (!bank_open || !row_hit) req_illegal = 1'b1;
        else                        load_val    = CNT_W'(T_WR - 1);
      end
      default: load_val = CNT_W'(T_RFC - 1);
    endcase
  end

  assign done = (state == EXEC) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      cmd_ack      <= 1'b0;
      busy         <= 1'b0;
      cmd_err      <= 1'b0;
      exec_rd      <= 1'b0;
      exec_wr      <= 1'b0;
      exec_bank    <= '0;
      exec_row     <= '0;
      exec_col     <= '0;
      exec_cmd     <= CMD_ACT;
      exec_illegal <= 1'b0;
      cnt          <= '0;
    end else begin
      cmd_err <= 1'b0;
      exec_rd <= 1'b0;
      exec_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_req) begin
            exec_bank    <= bank_id;
            exec_row     <= row_id;
            exec_col     <= col_id;
            exec_cmd     <= cmd;
            exec_illegal <= req_illegal;
            cnt          <= load_val;
            busy         <= 1'b1;
            state        <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            cmd_ack <= 1'b1;
            state   <= ACK;
            if (exec_illegal)          cmd_err <= 1'b1;
            else if (exec_cmd == CMD_RD) exec_rd <= 1'b1;
            else if (exec_cmd == CMD_WR) exec_wr <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
          if (!cmd_req) begin
            cmd_ack <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-bank open flag and row; REFRESH closes every bank but leaves stale rows harmlessly.
  generate
    for (genvar gi = 0; gi < NUMBER_OF_BANKS; gi++) begin : g_bank
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          open_mask[gi] <= 1'b0;
          open_row[gi]  <= '0;
        end else if (done && !exec_illegal) begin
          if (exec_cmd == CMD_REF) begin
            open_mask[gi] <= 1'b0;
          end else if (exec_cmd == CMD_ACT && exec_bank == BW'(gi)) begin
            open_mask[gi] <= 1'b1;
            open_row[gi]  <= exec_row;
          end
        end
      end
    end
  endgenerate

endmodule
